// File: rtl/sdram_init.sv
// SDRAM power-up initialization sequencer: power-up wait, precharge all, auto-refresh
// burst and mode-register load, then holds init_end until the next reset.
module sdram_init #(
    parameter int unsigned T_POWER  = 20000,
    parameter int unsigned T_RP     = 2,
    parameter int unsigned T_RFC    = 7,
    parameter int unsigned T_MRD    = 3,
    parameter int unsigned AR_NUM   = 8,
    parameter logic [12:0] MODE_REG = 13'b000_0_00_011_0_111
) (
    input  logic        init_clk,
    input  logic        init_rst_n,
    output logic        init_end,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_bank,
    output logic [12:0] init_addr
);

    localparam int unsigned MaxA   = (T_POWER > T_RP) ? T_POWER : T_RP;
    localparam int unsigned MaxB   = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax);
    localparam int unsigned ArW    = ($clog2(AR_NUM + 1) > 4) ? $clog2(AR_NUM + 1) : 4;

    localparam logic [CntW-1:0] PowerLast = CntW'(T_POWER - 1);
    localparam logic [CntW-1:0] RpLast    = CntW'(T_RP - 1);
    localparam logic [CntW-1:0] RfcLast   = CntW'(T_RFC - 1);
    localparam logic [CntW-1:0] MrdLast   = CntW'(T_MRD - 1);
    localparam logic [ArW-1:0]  ArNum     = ArW'(AR_NUM);

    localparam logic [3:0]  CmdNop  = 4'b0111;
    localparam logic [3:0]  CmdPre  = 4'b0010;
    localparam logic [3:0]  CmdAref = 4'b0001;
    localparam logic [3:0]  CmdLmr  = 4'b0000;
    localparam logic [12:0] AddrAll = 13'h1FFF;

    // Gray-coded so consecutive states differ in one bit
    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StPre  = 3'b001,
        StTrp  = 3'b011,
        StAr   = 3'b010,
        StTrfc = 3'b110,
        StMrs  = 3'b111,
        StTmrd = 3'b101,
        StEnd  = 3'b100
    } state_e;

    state_e          state_curr;
    state_e          state_next;
    logic [CntW-1:0] cnt;
    logic [ArW-1:0]  ar_cnt;

    always_comb begin
        state_next = state_curr;
        case (state_curr)
            StIdle:  if (cnt == PowerLast) state_next = StPre;
            StPre:   state_next = StTrp;
            StTrp:   if (cnt == RpLast) state_next = StAr;
            StAr:    state_next = StTrfc;
            StTrfc:  if (cnt == RfcLast) state_next = (ar_cnt < ArNum) ? StAr : StMrs;
            StMrs:   state_next = StTmrd;
            StTmrd:  if (cnt == MrdLast) state_next = StEnd;
            StEnd:   state_next = StEnd;
            default: state_next = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as state_curr
    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            state_curr <= StIdle;
            cnt        <= '0;
            ar_cnt     <= '0;
            init_end   <= 1'b0;
            init_cmd   <= CmdNop;
            init_bank  <= 2'b11;
            init_addr  <= AddrAll;
        end else begin
            state_curr <= state_next;

            if (state_next != state_curr) begin
                cnt <= '0;
            end else if (state_curr != StEnd) begin
                cnt <= cnt + 1'b1;
            end

            if (state_curr == StAr && ar_cnt != '1) begin
                ar_cnt <= ar_cnt + 1'b1;
            end

            init_end  <= (state_next == StEnd);
            init_cmd  <= CmdNop;
            init_bank <= 2'b11;
            init_addr <= AddrAll;
            case (state_next)
                StPre: init_cmd <= CmdPre;
                StAr:  init_cmd <= CmdAref;
                StMrs: begin
                    init_cmd  <= CmdLmr;
                    init_bank <= 2'b00;
                    init_addr <= MODE_REG;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_init.sv
// Bench for sdram_init: default-parameter instance checked cycle by cycle against a schedule
// model, plus a small-parameter instance hit with random asynchronous resets.
module tb_sdram_init;

    localparam logic [3:0]  NOP = 4'b0111;
    localparam logic [3:0]  PRE = 4'b0010;
    localparam logic [3:0]  ARF = 4'b0001;
    localparam logic [3:0]  LMR = 4'b0000;
    localparam logic [19:0] RST_VEC = {1'b0, 4'b0111, 2'b11, 13'h1FFF};
    localparam int          FIN = 20071;

    logic        clk;
    logic        rst_n;
    logic        rst_s;
    logic        end_m, end_s;
    logic [3:0]  cmd_m, cmd_s;
    logic [1:0]  bank_m, bank_s;
    logic [12:0] addr_m, addr_s;
    logic [19:0] out_m, out_s;

    int n_checks;
    int n_fail;
    int t_main;
    int t_s;
    logic [19:0] trace [0:21100];

    assign out_m = {end_m, cmd_m, bank_m, addr_m};
    assign out_s = {end_s, cmd_s, bank_s, addr_s};

    sdram_init u_dut (
        .init_clk   (clk),
        .init_rst_n (rst_n),
        .init_end   (end_m),
        .init_cmd   (cmd_m),
        .init_bank  (bank_m),
        .init_addr  (addr_m)
    );

    sdram_init #(
        .T_POWER (6),
        .T_RP    (1),
        .T_RFC   (2),
        .T_MRD   (1),
        .AR_NUM  (3)
    ) u_small (
        .init_clk   (clk),
        .init_rst_n (rst_s),
        .init_end   (end_s),
        .init_cmd   (cmd_s),
        .init_bank  (bank_s),
        .init_addr  (addr_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {end, cmd, bank, addr} t edges after reset release, from the command schedule
    function automatic logic [19:0] model(input int t, input int tp, input int trp,
                                          input int trfc, input int tmrd, input int arn);
        int pre, ar0, per, mrs, fin;
        pre = tp;
        ar0 = tp + 1 + trp;
        per = 1 + trfc;
        mrs = ar0 + arn * per;
        fin = mrs + 1 + tmrd;
        if (t >= fin) return {1'b1, NOP, 2'b11, 13'h1FFF};
        if (t == pre) return {1'b0, PRE, 2'b11, 13'h1FFF};
        if (t == mrs) return {1'b0, LMR, 2'b00, 13'h0037};
        if (t >= ar0 && t < mrs && ((t - ar0) % per) == 0) return {1'b0, ARF, 2'b11, 13'h1FFF};
        return {1'b0, NOP, 2'b11, 13'h1FFF};
    endfunction

    task automatic chk(input string name, input int t, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
        end
    endtask

    task automatic run_main(input int upto);
        while (t_main < upto) begin
            @(posedge clk);
            #1;
            t_main++;
            trace[t_main] = out_m;
            chk("main_seq", t_main, {12'd0, out_m}, {12'd0, model(t_main, 20000, 2, 7, 3, 8)});
            if (t_main >= FIN) chk("end_state", t_main, {29'd0, u_dut.state_curr}, 32'h4);
        end
    endtask

    task automatic release_main();
        rst_n  = 1'b1;
        t_main = 0;
        trace[0] = out_m;
        chk("release", 0, {12'd0, out_m}, {12'd0, RST_VEC});
    endtask

    task automatic check_main_reset(input string name, input int t);
        chk({name, "_out"}, t, {12'd0, out_m}, {12'd0, RST_VEC});
        chk({name, "_state"}, t, {29'd0, u_dut.state_curr}, 32'h0);
        chk({name, "_cnt"}, t, 32'(u_dut.cnt), 32'h0);
        chk({name, "_arcnt"}, t, 32'(u_dut.ar_cnt), 32'h0);
    endtask

    typedef struct {
        int          t;
        logic        e;
        logic [3:0]  cmd;
        logic [1:0]  bank;
        logic [12:0] addr;
    } vec_t;

    vec_t    vecs [15];
    int      cmd_t[$];
    logic [3:0] cmd_q[$];
    int      nop_cnt;
    int      rise_t;
    int      n_rand;
    int      hold;

    initial begin
        vecs[0]  = '{0,     1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[1]  = '{19999, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[2]  = '{20000, 1'b0, PRE, 2'b11, 13'h1FFF};
        vecs[3]  = '{20001, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[4]  = '{20002, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[5]  = '{20003, 1'b0, ARF, 2'b11, 13'h1FFF};
        vecs[6]  = '{20004, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[7]  = '{20011, 1'b0, ARF, 2'b11, 13'h1FFF};
        vecs[8]  = '{20059, 1'b0, ARF, 2'b11, 13'h1FFF};
        vecs[9]  = '{20060, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[10] = '{20067, 1'b0, LMR, 2'b00, 13'h0037};
        vecs[11] = '{20068, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[12] = '{20070, 1'b0, NOP, 2'b11, 13'h1FFF};
        vecs[13] = '{20071, 1'b1, NOP, 2'b11, 13'h1FFF};
        vecs[14] = '{21071, 1'b1, NOP, 2'b11, 13'h1FFF};

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rst_s    = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        check_main_reset("reset_hold", 0);
        release_main();
        run_main(FIN + 1000);

        foreach (vecs[i]) begin
            chk("vector", vecs[i].t, {12'd0, trace[vecs[i].t]},
                {12'd0, vecs[i].e, vecs[i].cmd, vecs[i].bank, vecs[i].addr});
        end

        nop_cnt = 0;
        for (int t = 0; t < 20000; t++) if (trace[t][18:15] == NOP) nop_cnt++;
        chk("powerup_nops", 0, 32'(nop_cnt), 32'd20000);
        chk("pre_a10", 20000, {31'd0, trace[20000][10]}, 32'd1);

        rise_t = -1;
        for (int t = 0; t <= FIN + 1000; t++) begin
            if (trace[t][18:15] != NOP) begin
                cmd_t.push_back(t);
                cmd_q.push_back(trace[t][18:15]);
            end
            if (rise_t < 0 && trace[t][19]) rise_t = t;
        end
        chk("cmd_count", 0, 32'(cmd_q.size()), 32'd10);
        if (cmd_q.size() == 10) begin
            chk("cmd_order_pre", cmd_t[0], {28'd0, cmd_q[0]}, {28'd0, PRE});
            for (int i = 1; i <= 8; i++) begin
                chk("cmd_order_ar", cmd_t[i], {28'd0, cmd_q[i]}, {28'd0, ARF});
            end
            chk("cmd_order_lmr", cmd_t[9], {28'd0, cmd_q[9]}, {28'd0, LMR});
            chk("pre_to_ar", cmd_t[1], 32'(cmd_t[1] - cmd_t[0]), 32'd3);
            for (int i = 2; i <= 8; i++) begin
                chk("ar_to_ar", cmd_t[i], 32'(cmd_t[i] - cmd_t[i-1]), 32'd8);
            end
            chk("ar_to_lmr", cmd_t[9], 32'(cmd_t[9] - cmd_t[8]), 32'd8);
            chk("lmr_to_end", rise_t, 32'(rise_t - cmd_t[9]), 32'd4);
        end
        chk("total_latency", 0, 32'(rise_t), 32'd20071);

        // Reset while in END aborts at once
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_main_reset("reset_in_end", t_main);
        repeat (10) @(posedge clk);
        #1;
        release_main();

        // Run into the wait after the 5th auto refresh, then reset there
        run_main(20038);
        chk("in_5th_trfc", t_main, {29'd0, u_dut.state_curr}, 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check_main_reset("reset_in_trfc", t_main);
        repeat (10) @(posedge clk);
        #1;
        release_main();
        run_main(FIN + 5);

        // Small instance: random run lengths and random asynchronous reset pulses
        rst_s = 1'b1;
        t_s   = 0;
        chk("small_release", 0, {12'd0, out_s}, {12'd0, RST_VEC});
        for (int it = 0; it < 40; it++) begin
            n_rand = int'($urandom_range(0, 30));
            repeat (n_rand) begin
                @(posedge clk);
                #1;
                t_s++;
                chk("small_seq", t_s, {12'd0, out_s}, {12'd0, model(t_s, 6, 1, 2, 1, 3)});
            end
            #($urandom_range(1, 3));
            rst_s = 1'b0;
            #1;
            chk("small_reset", t_s, {12'd0, out_s}, {12'd0, RST_VEC});
            chk("small_reset_state", t_s, {29'd0, u_small.state_curr}, 32'h0);
            hold = int'($urandom_range(1, 3));
            repeat (hold) @(posedge clk);
            #1;
            rst_s = 1'b1;
            t_s   = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
